// File: rtl/vcnpu_dram_pkg.sv
// Shared definitions for the NPU DRAM read bridge.
//   state_e        : bridge FSM states
//   BoundaryBytes  : address boundary a burst may not cross when 4 KB splitting is built in
//   BoundaryBits   : log2 of BoundaryBytes, the width of the in-boundary byte offset
package vcnpu_dram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StData,
    StDrain
  } state_e;

  localparam int unsigned BoundaryBytes = 4096;
  localparam int unsigned BoundaryBits  = 12;

endpackage

// File: rtl/vcnpu_sync_fifo.sv
// Synchronous return-data FIFO with a free-slot count for credit-based request issue.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers and count only)
//   push        : write push_data this edge (ignored when full)
//   pop         : advance read pointer this edge (ignored when empty)
//   pop_data    : word at the head of the FIFO (valid when !empty)
//   empty       : no words stored
//   free_cnt    : FIFO_DEPTH minus stored words
module vcnpu_sync_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [DATA_W-1:0]                 push_data,
  input  logic                              pop,
  output logic [DATA_W-1:0]                 pop_data,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   free_cnt
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              do_push, do_pop, full;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(FIFO_DEPTH));
  assign free_cnt = CntW'(FIFO_DEPTH) - cnt_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && !full;
  assign pop_data = mem_q[rd_ptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      // Simultaneous push and pop leaves the count unchanged.
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/vcnpu_dram_bridge.sv
// NPU-to-memory read bridge: splits an NPU read request into bursts on an AXI-like
// address/data channel pair and streams the returned words back through a FIFO.
// Optional build macro DRAM_BRIDGE_4K_SPLIT_EN: also clip bursts at 4096-byte boundaries.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   dram_req/addr/len, dram_ack         : NPU request (byte addr, length in words), accept pulse
//   dram_data_valid/dram_data_in        : returned word stream, no backpressure
//   mem_ar_valid/ready/addr/len         : burst address channel (len = beats-1)
//   mem_r_valid/ready/data/last/err     : burst data channel
//   busy, err                           : request in progress, sticky protocol/response error
module vcnpu_dram_bridge
  import vcnpu_dram_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dram_req,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [15:0]       dram_len,
  output logic              dram_ack,
  output logic              dram_data_valid,
  output logic [DATA_W-1:0] dram_data_in,
  output logic              mem_ar_valid,
  input  logic              mem_ar_ready,
  output logic [ADDR_W-1:0] mem_ar_addr,
  output logic [7:0]        mem_ar_len,
  input  logic              mem_r_valid,
  output logic              mem_r_ready,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_r_last,
  input  logic              mem_r_err,
  output logic              busy,
  output logic              err
);

  localparam int unsigned WordBytes = DATA_W / 8;
  localparam int unsigned WordShift = $clog2(WordBytes);
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH+1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       remaining_q;
  logic [8:0]        beats_q;
  logic [8:0]        beat_cnt_q;
  logic [16:0]       beats_calc;

  logic              fifo_push, fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic [CntW-1:0]   free_cnt;

`ifdef DRAM_BRIDGE_4K_SPLIT_EN
  logic [BoundaryBits:0] bytes_to_bound;
  logic [16:0]           words_to_bound;
`endif

  // Beats of the next burst, derived from the current address and remaining length.
  always_comb begin
    beats_calc = (remaining_q > 16'(MAX_BURST)) ? 17'(MAX_BURST) : {1'b0, remaining_q};
`ifdef DRAM_BRIDGE_4K_SPLIT_EN
    bytes_to_bound = (BoundaryBits+1)'(BoundaryBytes) - {1'b0, addr_q[BoundaryBits-1:0]};
    words_to_bound = 17'((bytes_to_bound + (BoundaryBits+1)'(WordBytes - 1)) >> WordShift);
    if (words_to_bound < beats_calc) beats_calc = words_to_bound;
`endif
  end

  assign fifo_push = mem_r_valid && mem_r_ready;

  vcnpu_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (mem_r_data),
    .pop       (!fifo_empty),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .free_cnt  (free_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      beats_q         <= '0;
      beat_cnt_q      <= '0;
      dram_ack        <= 1'b0;
      dram_data_valid <= 1'b0;
      dram_data_in    <= '0;
      mem_ar_valid    <= 1'b0;
      mem_ar_addr     <= '0;
      mem_ar_len      <= '0;
      mem_r_ready     <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
    end else begin
      dram_ack        <= 1'b0;
      dram_data_valid <= !fifo_empty;
      if (!fifo_empty) dram_data_in <= fifo_data;

      unique case (state_q)
        StIdle: begin
          if (dram_req) begin
            addr_q      <= dram_addr;
            remaining_q <= dram_len;
            dram_ack    <= 1'b1;
            if (dram_len != 16'd0) begin
              busy    <= 1'b1;
              state_q <= StIssue;
            end
          end
        end

        StIssue: begin
          if (!mem_ar_valid) begin
            // Credit rule: only ask for a burst the FIFO can fully absorb. Free slots
            // only grow while waiting, so the request stays legal until accepted.
            if (17'(free_cnt) >= beats_calc) begin
              mem_ar_valid <= 1'b1;
              mem_ar_addr  <= addr_q;
              mem_ar_len   <= 8'(beats_calc - 17'd1);
            end
          end else if (mem_ar_ready) begin
            mem_ar_valid <= 1'b0;
            mem_r_ready  <= 1'b1;
            beats_q      <= 9'(beats_calc);
            beat_cnt_q   <= '0;
            addr_q       <= addr_q + (ADDR_W'(beats_calc) << WordShift);
            remaining_q  <= remaining_q - 16'(beats_calc);
            state_q      <= StData;
          end
        end

        StData: begin
          if (fifo_push) begin
            if (mem_r_err) err <= 1'b1;
            // The beat count, not mem_r_last, decides where the burst ends.
            if (beat_cnt_q == beats_q - 9'd1) begin
              if (!mem_r_last) err <= 1'b1;
              mem_r_ready <= 1'b0;
              state_q     <= (remaining_q != 16'd0) ? StIssue : StDrain;
            end else begin
              if (mem_r_last) err <= 1'b1;
              beat_cnt_q <= beat_cnt_q + 9'd1;
            end
          end
        end

        StDrain: begin
          if (fifo_empty) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vcnpu_dram_bridge.sv
// Directed self-checking bench for vcnpu_dram_bridge with a behavioural burst memory.
module tb_vcnpu_dram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dram_req;
  logic [31:0] dram_addr;
  logic [15:0] dram_len;
  logic        dram_ack;
  logic        dram_data_valid;
  logic [15:0] dram_data_in;
  logic        mem_ar_valid;
  logic        mem_ar_ready;
  logic [31:0] mem_ar_addr;
  logic [7:0]  mem_ar_len;
  logic        mem_r_valid;
  logic        mem_r_ready;
  logic [15:0] mem_r_data;
  logic        mem_r_last;
  logic        mem_r_err;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  vcnpu_dram_bridge dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dram_req        (dram_req),
    .dram_addr       (dram_addr),
    .dram_len        (dram_len),
    .dram_ack        (dram_ack),
    .dram_data_valid (dram_data_valid),
    .dram_data_in    (dram_data_in),
    .mem_ar_valid    (mem_ar_valid),
    .mem_ar_ready    (mem_ar_ready),
    .mem_ar_addr     (mem_ar_addr),
    .mem_ar_len      (mem_ar_len),
    .mem_r_valid     (mem_r_valid),
    .mem_r_ready     (mem_r_ready),
    .mem_r_data      (mem_r_data),
    .mem_r_last      (mem_r_last),
    .mem_r_err       (mem_r_err),
    .busy            (busy),
    .err             (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Memory model configuration and observations.
  int          ar_delay    = 0;
  int          early_idx   = -1;
  bit          stable_ok   = 1'b1;
  logic [31:0] burst_addr_q[$];
  logic [7:0]  burst_len_q[$];
  logic [15:0] rx_q[$];
  int          first_beat_cyc  = -1;
  int          first_valid_cyc = -1;
  int          ack_cnt = 0;
  int          arv_cnt = 0;
  int          busy_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input logic [31:0] a);
    return a[16:1] ^ 16'hA5A5;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dram_data_valid) begin
        rx_q.push_back(dram_data_in);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (dram_ack)     ack_cnt++;
      if (mem_ar_valid) arv_cnt++;
      if (busy)         busy_cnt++;
    end
  end

  // Burst memory: optional AR stall, then one beat per cycle.
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    mem_ar_ready = 1'b0;
    mem_r_valid  = 1'b0;
    mem_r_data   = '0;
    mem_r_last   = 1'b0;
    mem_r_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_ar_valid) begin
        a = mem_ar_addr;
        l = mem_ar_len;
        for (int i = 0; i < ar_delay; i++) begin
          @(negedge clk);
          if (mem_ar_addr !== a || mem_ar_len !== l || mem_ar_valid !== 1'b1) stable_ok = 1'b0;
        end
        mem_ar_ready = 1'b1;
        burst_addr_q.push_back(a);
        burst_len_q.push_back(l);
        @(negedge clk);
        mem_ar_ready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
          if (!rst_n) break;
          mem_r_valid = 1'b1;
          mem_r_data  = word_at(a + 32'(2 * b));
          mem_r_last  = (early_idx >= 0) ? (b == early_idx) : (b == int'(l));
          if (first_beat_cyc < 0) first_beat_cyc = cyc;
          @(negedge clk);
        end
        mem_r_valid = 1'b0;
        mem_r_last  = 1'b0;
      end
    end
  end

  task automatic clear_obs();
    burst_addr_q.delete();
    burst_len_q.delete();
    rx_q.delete();
    first_beat_cyc  = -1;
    first_valid_cyc = -1;
    ack_cnt  = 0;
    arv_cnt  = 0;
    busy_cnt = 0;
    stable_ok = 1'b1;
  endtask

  task automatic run_req(input logic [31:0] a, input logic [15:0] l);
    int n;
    @(negedge clk);
    dram_req  = 1'b1;
    dram_addr = a;
    dram_len  = l;
    @(negedge clk);
    dram_req = 1'b0;
    chk("ack_pulse", dram_ack, 1'b1);
    chk("busy_on_accept", busy, (l != 16'd0));
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("busy_timeout", 1'b1, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_words(input logic [31:0] a, input int n);
    chk("word_count", rx_q.size(), n);
    for (int i = 0; i < rx_q.size() && i < n; i++)
      chk($sformatf("word[%0d]", i), rx_q[i], word_at(a + 32'(2 * i)));
  endtask

  task automatic chk_burst(input int i, input logic [31:0] a, input logic [7:0] l);
    if (i < burst_addr_q.size()) begin
      chk($sformatf("burst%0d_addr", i), burst_addr_q[i], a);
      chk($sformatf("burst%0d_len", i), burst_len_q[i], l);
    end else begin
      chk($sformatf("burst%0d_missing", i), 1'b0, 1'b1);
    end
  endtask

  initial begin
    int n;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    dram_req  = 1'b0;
    dram_addr = '0;
    dram_len  = '0;
    #3;
    chk("rst_ack", dram_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_arvalid", mem_ar_valid, 1'b0);
    chk("rst_rready", mem_r_ready, 1'b0);
    chk("rst_dvalid", dram_data_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 40 words from 0x1000_0000: bursts 16,16,8.
    clear_obs();
    run_req(32'h1000_0000, 16'd40);
    chk("t1_nbursts", burst_addr_q.size(), 3);
    chk_burst(0, 32'h1000_0000, 8'd15);
    chk_burst(1, 32'h1000_0020, 8'd15);
    chk_burst(2, 32'h1000_0040, 8'd7);
    chk_words(32'h1000_0000, 40);
    chk("t1_latency", first_valid_cyc - first_beat_cyc, 2);
    chk("t1_err", err, 1'b0);

    // Zero-length request: ack only.
    clear_obs();
    run_req(32'h1000_0100, 16'd0);
    repeat (5) @(negedge clk);
    chk("t2_acks", ack_cnt, 1);
    chk("t2_arvalid_cycles", arv_cnt, 0);
    chk("t2_busy_cycles", busy_cnt, 0);

    // Ignored request while busy, then AR stalled 20 cycles.
    clear_obs();
    ar_delay = 20;
    @(negedge clk);
    dram_req = 1'b1; dram_addr = 32'h2000_0000; dram_len = 16'd16;
    @(negedge clk);
    dram_addr = 32'h2222_0000; dram_len = 16'd4;
    @(negedge clk);
    dram_req = 1'b0;
    chk("t3_no_ack_busy", dram_ack, 1'b0);
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("t3_busy_timeout", 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    ar_delay = 0;
    chk("t3_acks", ack_cnt, 1);
    chk("t3_ar_stable", stable_ok, 1'b1);
    chk("t3_nbursts", burst_addr_q.size(), 1);
    chk_burst(0, 32'h2000_0000, 8'd15);
    chk_words(32'h2000_0000, 16);
    chk("t3_err", err, 1'b0);

    // 4 KB boundary crossing.
    clear_obs();
    run_req(32'h0000_0FF8, 16'd16);
`ifdef DRAM_BRIDGE_4K_SPLIT_EN
    chk("t5_nbursts", burst_addr_q.size(), 2);
    chk_burst(0, 32'h0000_0FF8, 8'd3);
    chk_burst(1, 32'h0000_1000, 8'd11);
`else
    chk("t5_nbursts", burst_addr_q.size(), 1);
    chk_burst(0, 32'h0000_0FF8, 8'd15);
`endif
    chk_words(32'h0000_0FF8, 16);
    chk("t5_err", err, 1'b0);

    // Early last on beat 5 of 16.
    clear_obs();
    early_idx = 4;
    run_req(32'h4000_0000, 16'd16);
    early_idx = -1;
    chk_words(32'h4000_0000, 16);
    chk("t4_err_set", err, 1'b1);
    repeat (10) @(negedge clk);
    chk("t4_err_sticky", err, 1'b1);

    // Reset during burst 2, then a fresh request.
    clear_obs();
    @(negedge clk);
    dram_req = 1'b1; dram_addr = 32'h1000_0000; dram_len = 16'd40;
    @(negedge clk);
    dram_req = 1'b0;
    n = 0;
    while (burst_addr_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("t6_burst2_timeout", 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    chk("t6_rst_rready", mem_r_ready, 1'b0);
    chk("t6_rst_arvalid", mem_ar_valid, 1'b0);
    chk("t6_rst_dvalid", dram_data_valid, 1'b0);
    chk("t6_rst_ddata", dram_data_in, 16'h0);
    chk("t6_rst_ack", dram_ack, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_obs();
    run_req(32'h3000_0000, 16'd8);
    chk("t6_nbursts", burst_addr_q.size(), 1);
    chk_burst(0, 32'h3000_0000, 8'd7);
    chk_words(32'h3000_0000, 8);
    chk("t6_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vcnpu_dram_bridge.md
VCNPU_DRAM_BRIDGE -- requirements
Module: vcnpu_dram_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width of returned data.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per memory burst (power of two, 1..256).
REQ-004 SHALL have parameter FIFO_DEPTH, default 32, return-data FIFO depth in words (power of two, >= MAX_BURST).
REQ-005 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports dram_req / dram_addr / dram_len, input, 1 / ADDR_W / 16: NPU read request, byte start address and length in words.
REQ-008 SHALL have port dram_ack, output, 1: one-cycle pulse when a request is accepted.
REQ-009 SHALL have ports dram_data_valid / dram_data_in, output, 1 / DATA_W: returned word stream to the NPU, no backpressure.
REQ-010 SHALL have ports mem_ar_valid / mem_ar_ready / mem_ar_addr / mem_ar_len, output / input / output / output, 1 / 1 / ADDR_W / 8: burst address channel, len = beats-1.
REQ-011 SHALL have ports mem_r_valid / mem_r_ready / mem_r_data / mem_r_last / mem_r_err, input / output / input / input / input, 1 / 1 / DATA_W / 1 / 1: burst data channel.
REQ-012 SHALL have ports busy and err, output, 1: request in progress; sticky protocol/response error.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> DATA -> (ISSUE | DRAIN) -> IDLE.
REQ-014 IDLE: dram_req=1 SHALL latch addr/len, pulse dram_ack next cycle, go to ISSUE (len>0) or stay IDLE with no bursts (len=0, ack still pulsed).
REQ-015 dram_req while busy=1 SHALL be ignored, no ack; NPU re-asserts.
REQ-016 ISSUE: burst beats = min(remaining, MAX_BURST); mem_ar_valid SHALL assert only when free FIFO slots >= burst beats (credit rule, no overflow possible).
REQ-017 mem_ar_valid, addr, len SHALL hold stable until mem_ar_ready; on handshake go to DATA, next addr += beats*(DATA_W/8), remaining -= beats.
REQ-018 DATA: mem_r_ready SHALL be 1; each mem_r_valid beat SHALL be pushed to the FIFO same edge.
REQ-019 Final expected beat SHALL coincide with mem_r_last; early or missing last, or mem_r_err on any beat, SHALL set err (sticky until reset); data still forwarded, beat count governs burst end.
REQ-020 After the burst: remaining>0 -> ISSUE, else DRAIN; DRAIN -> IDLE when FIFO empty.
REQ-021 One burst outstanding at a time.
REQ-022 FIFO SHALL pop whenever non-empty; dram_data_valid/dram_data_in registered, minimum latency mem_r_valid -> dram_data_valid = 2 cycles.
REQ-023 Simultaneous FIFO push and pop SHALL both occur; pointers wrap modulo FIFO_DEPTH.
REQ-024 busy SHALL be 1 from acceptance edge until DRAIN exits.

Reset
REQ-025 On rst_n low all outputs SHALL be 0, FSM IDLE, FIFO empty, err cleared, immediately and asynchronously.
REQ-026 Reset mid-burst SHALL discard outstanding beats; memory-side recovery is the system's responsibility.

Configuration
REQ-027 With DRAM_BRIDGE_4K_SPLIT_EN defined, burst beats SHALL additionally be clipped so no burst crosses a 4096-byte address boundary.
REQ-028 Without DRAM_BRIDGE_4K_SPLIT_EN, bursts SHALL be split by MAX_BURST and remaining length only.

Structure
REQ-029 Shared package vcnpu_dram_pkg SHALL hold the FSM state enum and the 4 KB boundary constant.
REQ-030 Return FIFO SHALL be a sub-module vcnpu_sync_fifo (parameters DATA_W, FIFO_DEPTH; exposes free-slot count).

Verification
REQ-031 addr=0x1000_0000, len=40, ready memory -> bursts 16,16,8 at 0x1000_0000/0x1000_0020/0x1000_0040; 40 dram_data_valid words in order; err=0.
REQ-032 len=0 -> single dram_ack, no mem_ar_valid, busy stays 0.
REQ-033 mem_ar_ready held 0 for 20 cycles -> ar addr/len stable throughout; completes after ready.
REQ-034 mem_r_last on beat 5 of a 16-beat burst -> err=1 and stays 1; remaining words delivered.
REQ-035 With DRAM_BRIDGE_4K_SPLIT_EN: addr=0x0000_0FF8, len=16 -> bursts of 4 then 12 beats; without macro -> one 16-beat burst.
REQ-036 rst_n low during burst 2 -> all outputs 0 same cycle; new request after release completes correctly.
